// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// seg7_scan_driver : frame-snapshotted, ghost-guarded 4-digit common-anode scan
// Revision: 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned   PRESCALE_W = 24;
    localparam logic [PRESCALE_W-1:0] TICK_COUNT = PRESCALE_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_DRIVE = 2'd1,
        ST_OFF   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [PRESCALE_W-1:0]   prescaler, prescaler_next;
    logic [1:0]              idx, idx_next;
    logic [15:0]             shadow, shadow_next;
    logic [3:0]              shadow_dp, shadow_dp_next;
    logic [3:0]              an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;
    logic                    frame_start_next;
    logic                    tick;
    logic [3:0]              digit_sel;
    logic                    lz3, lz2, lz1;
    logic                    blanked;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    assign tick = (prescaler == TICK_COUNT);

    always_comb begin
        state_next       = state;
        prescaler_next   = prescaler;
        idx_next         = idx;
        shadow_next      = shadow;
        shadow_dp_next   = shadow_dp;
        frame_start_next = 1'b0;

        if (!en) begin
            state_next = ST_OFF;
        end else begin
            prescaler_next = tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx_next   = idx + 2'd1;
                state_next = ST_GUARD;
                // Snapshot only at the frame boundary so a frame never tears.
                if (idx == 2'd3) begin
                    shadow_next      = digits_in;
                    shadow_dp_next   = dp_in;
                    frame_start_next = 1'b1;
                end
            end else if (state == ST_OFF) begin
                state_next = ST_GUARD;
            end else begin
                state_next = ST_DRIVE;
            end
        end
    end

    // Outputs are decoded from the next-state values so the registered pins
    // line up with the registered state on the same edge.
    always_comb begin
        digit_sel = shadow_next[{idx_next, 2'b00} +: 4];
        lz3       = (shadow_next[15:12] == 4'h0);
        lz2       = lz3 && (shadow_next[11:8] == 4'h0);
        lz1       = lz2 && (shadow_next[7:4] == 4'h0);

        case (idx_next)
            2'd3:    blanked = blank_lz && lz3;
            2'd2:    blanked = blank_lz && lz2;
            2'd1:    blanked = blank_lz && lz1;
            default: blanked = 1'b0;
        endcase

        an_next  = 4'hF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (state_next == ST_DRIVE && !blanked) begin
            an_next  = ~(4'b0001 << idx_next);
            seg_next = hex_to_seg(digit_sel);
            dp_next  = ~shadow_dp_next[idx_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_GUARD;
            prescaler   <= '0;
            idx         <= 2'd0;
            shadow      <= 16'h0;
            shadow_dp   <= 4'h0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            prescaler   <= prescaler_next;
            idx         <= idx_next;
            shadow      <= shadow_next;
            shadow_dp   <= shadow_dp_next;
            an          <= an_next;
            seg         <= seg_next;
            dp          <= dp_next;
            frame_start <= frame_start_next;
        end
    end

endmodule
`default_nettype wire
